// File: rtl/ucode_store.sv
// Writable 16-entry microcode control store with a checksum-verified host loader.
// The sequencer reads a registered microword; the store stalls the core until a load succeeds.
module ucode_store #(
   parameter int UW = 17
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    adr,
   output logic [UW-1:0] uword,
   output logic          stall,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [UW-1:0] ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   output logic          ld_err,
   output logic [4:0]    ld_count,
   output logic [1:0]    dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] CSUM = 2'd2;

   // Handshake: a word moves when ld_valid & ld_ready at a rising edge; ld_ready is
   // high in LOAD and CSUM only, and a concurrent ld_start discards the word.

   logic [1:0]    state;
   logic [4:0]    count;
   logic [UW-1:0] acc;
   logic          loaded;
   logic          done_q;
   logic          err_q;
   logic          xfer;
   logic [UW-1:0] mem [16];

   assign ld_ready  = (state == LOAD) || (state == CSUM);
   assign xfer      = ld_valid && ld_ready && !ld_start;
   assign stall     = !loaded || (state != IDLE);
   assign ld_done   = done_q;
   assign ld_err    = err_q;
   assign ld_count  = count;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= 5'd0;
         acc    <= '0;
         loaded <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (ld_start) begin
            state  <= LOAD;
            count  <= 5'd0;
            acc    <= '0;
            loaded <= 1'b0;
         end else if (xfer) begin
            if (state == LOAD) begin
               acc   <= acc ^ ld_data;
               count <= count + 5'd1;
               if (count == 5'd15)
                  state <= CSUM;
            end else begin
               if (ld_data == acc) begin
                  loaded <= 1'b1;
                  done_q <= 1'b1;
               end else begin
                  err_q  <= 1'b1;
               end
               state <= IDLE;
            end
         end
      end
   end

   // Storage is deliberately not reset; only the loader may fill it.
   always_ff @(posedge clk) begin
      if (xfer && (state == LOAD))
         mem[count[3:0]] <= ld_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         uword <= '0;
      else
         uword <= stall ? '0 : mem[adr];
   end

endmodule
